// File: rtl/hamming_enc_seq_pkg.sv
// Shared definitions for the Hamming (16,11) encode/decode sequencers:
// sequencer states and bit positions inside the parity vector.
package hamming_enc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_CAP,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } state_t;

  localparam int MSG_W = 11;
  localparam int PAR_W = 5;

  // Positions inside the {p8,p4,p2,p1,p0} parity vector.
  localparam int P8_BIT = 4;
  localparam int P4_BIT = 3;
  localparam int P2_BIT = 2;
  localparam int P1_BIT = 1;
  localparam int P0_BIT = 0;

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming (16,11) parity generator: msg[k-1] is data bit bk,
// output is {p8,p4,p2,p1,p0} with p0 the overall even parity.
module hamming_parity_gen
  import hamming_enc_seq_pkg::*;
(
  input  logic [MSG_W-1:0] msg,
  output logic [PAR_W-1:0] par
);

  logic p8, p4, p2, p1;

  assign p8 = ^msg[10:4];
  assign p4 = ^{msg[10], msg[9], msg[8], msg[7], msg[3], msg[2], msg[1]};
  assign p2 = ^{msg[10], msg[9], msg[6], msg[5], msg[3], msg[2], msg[0]};
  assign p1 = ^{msg[10], msg[8], msg[6], msg[4], msg[3], msg[1], msg[0]};

  always_comb begin
    par         = '0;
    par[P8_BIT] = p8;
    par[P4_BIT] = p4;
    par[P2_BIT] = p2;
    par[P1_BIT] = p1;
    par[P0_BIT] = (^msg) ^ p8 ^ p4 ^ p2 ^ p1;
  end

endmodule

// File: rtl/hamming_enc_seq.sv
// Hamming (16,11) encode sequencer: reads NUM_WORDS byte-pair messages from
// data memory and writes each 16-bit codeword back as two bytes.
module hamming_enc_seq
  import hamming_enc_seq_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 15,
  parameter int unsigned SRC_BASE  = 0,
  parameter int unsigned DST_BASE  = 30,
  parameter int unsigned AW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           lo_q, lo_d, hi_q, hi_d;
  logic [MSG_W-1:0]     msg;
  logic [PAR_W-1:0]     par;
  logic [AW-1:0]        pair_off, src_lo, dst_lo;

  assign msg      = {hi_q[2:0], lo_q};
  assign pair_off = AW'({idx_q, 1'b0});
  assign src_lo   = AW'(SRC_BASE) + pair_off;
  assign dst_lo   = AW'(DST_BASE) + pair_off;

  hamming_parity_gen u_parity (
    .msg (msg),
    .par (par)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_RD_LO;
        idx_d   = '0;
      end
      ST_RD_LO: state_d = ST_RD_HI;
      ST_RD_HI: begin
        lo_d    = mem_rd_data;
        state_d = ST_CAP;
      end
      ST_CAP: begin
        hi_d    = mem_rd_data;
        state_d = ST_WR_LO;
      end
      ST_WR_LO: state_d = ST_WR_HI;
      ST_WR_HI: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_RD_LO;
        end
      end
      ST_DONE: if (!start) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port and status are pure decodes of the registered state.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    unique case (state_q)
      ST_RD_LO: begin
        busy     = 1'b1;
        mem_addr = src_lo;
      end
      ST_RD_HI: begin
        busy     = 1'b1;
        mem_addr = src_lo + AW'(1);
      end
      ST_CAP: busy = 1'b1;
      ST_WR_LO: begin
        busy        = 1'b1;
        mem_addr    = dst_lo;
        mem_wr_en   = 1'b1;
        mem_wr_data = {msg[3], msg[2], msg[1], par[P4_BIT],
                       msg[0], par[P2_BIT], par[P1_BIT], par[P0_BIT]};
      end
      ST_WR_HI: begin
        busy        = 1'b1;
        mem_addr    = dst_lo + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = {msg[10:4], par[P8_BIT]};
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
